commit_trace_tx: RTL
====================

# commit_trace_tx

Hardware commit-trace transmitter for the pipelined processor. Samples the writeback/memory-stage commit signals every cycle (register write, load, store, halt, cache hit/request strobes), buffers each committing cycle as one event in a small FIFO, and serializes the events as 16-bit words over a valid/ready stream to an off-core trace sink. On halt it appends a summary record of the run counters and then goes quiet until reset. It is the producing end of the REG/LOAD/STORE/HALT trace format the simulation bench writes.

## Interface
- DEPTH, 8: event FIFO entries (power of two, ≥2)
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous and active-low
- reg_write  in  1  register file written this cycle
- write_reg  in  3  destination register
- write_data  in  16  register write data
- mem_read  in  1  load in memory stage
- mem_write  in  1  store in memory stage
- mem_addr  in  16  memory address
- mem_data_in  in  16  store data
- mem_data_out  in  16  load data
- halt  in  1  halt in writeback
- icache_req, icache_hit, dcache_req, dcache_hit  in  1 each  cache strobes
- out_valid  out  1  word valid
- out_data  out  16  trace word
- out_ready  in  1  sink accepts word
- overflow  out  1  sticky: an event was dropped
- done  out  1  final halt word accepted

## Operation
- Capture: while not halted, a cycle with reg_write|mem_read|mem_write|halt is an event. Entry = {halt, mem_write, mem_read, reg_write, write_reg, write_data, mem_addr, mem_data}; mem_data = mem_data_out if mem_read else mem_data_in.
- Push only when FIFO count < DEPTH (count before any same-cycle pop). Otherwise event dropped, overflow set (cleared only by reset). A dropped halt still sets halted.
- Counters (16-bit, saturate at 0xFFFF): inst (halt|reg_write|mem_write), icache_req, icache_hit, dcache_req, dcache_hit. Increment every non-halted cycle regardless of FIFO state; frozen from the cycle halt is sampled (inclusive).
- Serializer emits records for head entry in order REG, LOAD, STORE, HALT, skipping absent ones:
  - REG: header {2'b00, 11'b0, write_reg}, then write_data.
  - LOAD: header 16'h4000, then mem_addr, then mem_data.
  - STORE: header 16'h8000, then mem_addr, then mem_data.
  - HALT: header 16'hC000, then inst, icache_hit, dcache_hit, icache_req, dcache_req.
- States: IDLE (no head) → EMIT (word index per record type) → next record or POP; after HALT's last word → DONE (done=1, out_valid=0) until reset.
- Entry popped on handshake of its last word.

## Timing
- Reset: out_valid=0, out_data=0, overflow=0, done=0, FIFO empty, counters 0, halted=0.
- Event sampled at edge k → first word out_valid=1 after edge k+1 (out_valid/out_data registered).
- Handshake: word transfers on out_valid&&out_ready at rising edge; while out_valid&&!out_ready, out_data held stable. Next word presented the following cycle; back-to-back transfers at one word/cycle with out_ready held high, including across entries.
- Halt sampled with empty FIFO → HALT header after edge k+1; counter words reflect values including cycle k.
- Inputs after halt sampled are ignored (no capture, no counting, no overflow).
- Reset asserted mid-record: stream aborts immediately, partial record discarded.

## Test plan
- reg_write, write_reg=3, write_data=16'hBEEF one cycle, out_ready=1 → words 16'h0003, 16'hBEEF; inst counter=1.
- Same cycle reg_write r5=16'h0012 and mem_read addr 16'h0100 data_out 16'h0012 → 16'h0005, 16'h0012, 16'h4000, 16'h0100, 16'h0012.
- Store addr 16'h0020 data 16'h00AA with out_ready low 5 cycles → out_data 16'h8000 held 5 cycles, then 16'h8000, 16'h0020, 16'h00AA on consecutive cycles.
- DEPTH=2, out_ready=0, three reg-write events → overflow=1, only first two events emitted after out_ready=1.
- 4 reg writes, 3 icache_hit, 2 dcache_req, then halt → REG records then 16'hC000, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 16'h0002; done=1; subsequent reg_write produces nothing.
- Assert rst_n low after LOAD header accepted → out_valid=0, done=0, overflow=0 asynchronously; new event after release streams normally.

Source files
------------

// File: rtl/commit_trace_tx_if.sv
// Commit-trace bundle: the per-cycle commit strobes from the core plus the
// outgoing 16-bit trace stream and its status flags.
// Ports: master = core/sink side (drives commits and out_ready), slave = transmitter.
interface commit_trace_tx_if;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        halt;
    logic        icache_req;
    logic        icache_hit;
    logic        dcache_req;
    logic        dcache_hit;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        overflow;
    logic        done;

    modport master (
        output reg_write, write_reg, write_data, mem_read, mem_write, mem_addr,
               mem_data_in, mem_data_out, halt, icache_req, icache_hit,
               dcache_req, dcache_hit, out_ready,
        input  out_valid, out_data, overflow, done
    );

    modport slave (
        input  reg_write, write_reg, write_data, mem_read, mem_write, mem_addr,
               mem_data_in, mem_data_out, halt, icache_req, icache_hit,
               dcache_req, dcache_hit, out_ready,
        output out_valid, out_data, overflow, done
    );
endinterface

// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: captures commit events into a FIFO and serializes REG/LOAD/STORE/HALT records.
// Latency: event sampled at edge k gives its first word valid after edge k+1; one word per cycle when ready.
// Backpressure: out_data held while out_valid && !out_ready; a full FIFO drops events and sets sticky overflow.
// Ports: clk, rst_n (async active-low), bus (slave modport: commit strobes in, trace stream + overflow/done out).
module commit_trace_tx #(
    parameter int DEPTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    commit_trace_tx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] REC_REG   = 2'd0;
    localparam logic [1:0] REC_LOAD  = 2'd1;
    localparam logic [1:0] REC_STORE = 2'd2;
    localparam logic [1:0] REC_HALT  = 2'd3;

    typedef struct packed {
        logic        halt;
        logic        mem_write;
        logic        mem_read;
        logic        reg_write;
        logic [2:0]  write_reg;
        logic [15:0] write_data;
        logic [15:0] mem_addr;
        logic [15:0] mem_data;
    } ent_t;

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    ent_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] count;
    logic          halted, overflow_q;
    logic [15:0]   cnt_inst, cnt_ireq, cnt_ihit, cnt_dreq, cnt_dhit;

    state_t        state, state_n;
    logic [1:0]    rec, rec_n;
    logic [2:0]    widx, widx_n;
    logic          out_valid_q, out_valid_n;
    logic [15:0]   out_data_q, out_data_n;
    logic          pop;
    logic [2:0]    nr;

    // ---------------- capture ----------------
    logic capture, push;
    ent_t entry;
    assign capture = !halted && (bus.reg_write || bus.mem_read || bus.mem_write || bus.halt);
    // Space is judged on the pre-pop count so a full FIFO never relies on a same-cycle drain.
    assign push    = capture && (count < FULL);
    assign entry   = '{halt: bus.halt, mem_write: bus.mem_write, mem_read: bus.mem_read,
                       reg_write: bus.reg_write, write_reg: bus.write_reg,
                       write_data: bus.write_data, mem_addr: bus.mem_addr,
                       mem_data: bus.mem_read ? bus.mem_data_out : bus.mem_data_in};
    assign rd_nxt  = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            halted     <= 1'b0;
            overflow_q <= 1'b0;
            cnt_inst   <= '0;
            cnt_ireq   <= '0;
            cnt_ihit   <= '0;
            cnt_dreq   <= '0;
            cnt_dhit   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_nxt;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (capture && !push) overflow_q <= 1'b1;
            // Counters include the halt cycle itself, then freeze for good.
            if (!halted) begin
                if (bus.halt) halted <= 1'b1;
                if ((bus.halt || bus.reg_write || bus.mem_write) && cnt_inst != 16'hFFFF)
                    cnt_inst <= cnt_inst + 1'b1;
                if (bus.icache_req && cnt_ireq != 16'hFFFF) cnt_ireq <= cnt_ireq + 1'b1;
                if (bus.icache_hit && cnt_ihit != 16'hFFFF) cnt_ihit <= cnt_ihit + 1'b1;
                if (bus.dcache_req && cnt_dreq != 16'hFFFF) cnt_dreq <= cnt_dreq + 1'b1;
                if (bus.dcache_hit && cnt_dhit != 16'hFFFF) cnt_dhit <= cnt_dhit + 1'b1;
            end
        end
    end

    // ---------------- serializer helpers ----------------
    function automatic logic [3:0] pres(input ent_t e);
        return {e.halt, e.mem_write, e.mem_read, e.reg_write};
    endfunction

    // First present record at or after 'start'; bit 2 set means none left.
    function automatic logic [2:0] next_rec(input logic [3:0] p, input logic [2:0] start);
        logic [2:0] res;
        res = 3'b100;
        for (int r = 3; r >= 0; r--) begin
            if (3'(r) >= start && p[r]) res = {1'b0, 2'(r)};
        end
        return res;
    endfunction

    function automatic logic [2:0] last_idx(input logic [1:0] r);
        case (r)
            REC_REG:  return 3'd1;
            REC_HALT: return 3'd5;
            default:  return 3'd2;
        endcase
    endfunction

    function automatic logic [15:0] word_of(input ent_t e, input logic [1:0] r, input logic [2:0] i);
        logic [15:0] w;
        w = '0;
        case (r)
            REC_REG:   w = (i == 3'd0) ? {13'b0, e.write_reg} : e.write_data;
            REC_LOAD, REC_STORE: begin
                case (i)
                    3'd0:    w = (r == REC_LOAD) ? 16'h4000 : 16'h8000;
                    3'd1:    w = e.mem_addr;
                    default: w = e.mem_data;
                endcase
            end
            default: begin
                case (i)
                    3'd0:    w = 16'hC000;
                    3'd1:    w = cnt_inst;
                    3'd2:    w = cnt_ihit;
                    3'd3:    w = cnt_dhit;
                    3'd4:    w = cnt_ireq;
                    default: w = cnt_dreq;
                endcase
            end
        endcase
        return w;
    endfunction

    // ---------------- serializer FSM ----------------
    always_comb begin
        state_n     = state;
        rec_n       = rec;
        widx_n      = widx;
        out_valid_n = out_valid_q;
        out_data_n  = out_data_q;
        pop         = 1'b0;
        nr          = '0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    nr          = next_rec(pres(mem[rd_ptr]), 3'd0);
                    rec_n       = nr[1:0];
                    widx_n      = '0;
                    out_valid_n = 1'b1;
                    out_data_n  = word_of(mem[rd_ptr], nr[1:0], 3'd0);
                    state_n     = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (widx == last_idx(rec)) begin
                        nr = next_rec(pres(mem[rd_ptr]), {1'b0, rec} + 3'd1);
                        if (!nr[2]) begin
                            rec_n      = nr[1:0];
                            widx_n     = '0;
                            out_data_n = word_of(mem[rd_ptr], nr[1:0], 3'd0);
                        end else if (rec == REC_HALT) begin
                            state_n     = DONE;
                            out_valid_n = 1'b0;
                            out_data_n  = '0;
                        end else begin
                            pop = 1'b1;
                            // Roll straight into the next entry to keep one word per cycle.
                            if (count > CW'(1)) begin
                                nr         = next_rec(pres(mem[rd_nxt]), 3'd0);
                                rec_n      = nr[1:0];
                                widx_n     = '0;
                                out_data_n = word_of(mem[rd_nxt], nr[1:0], 3'd0);
                            end else begin
                                state_n     = IDLE;
                                out_valid_n = 1'b0;
                            end
                        end
                    end else begin
                        widx_n     = widx + 3'd1;
                        out_data_n = word_of(mem[rd_ptr], rec, widx + 3'd1);
                    end
                end
            end
            default: out_valid_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rec         <= REC_REG;
            widx        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state       <= state_n;
            rec         <= rec_n;
            widx        <= widx_n;
            out_valid_q <= out_valid_n;
            out_data_q  <= out_data_n;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.overflow  = overflow_q;
    assign bus.done      = (state == DONE);
endmodule
